execute_stage: RTL and testbench

Execute stage of the pipelined ARM calculator core. It sits directly downstream of the register-file/decode stage and consumes its RD1/RD2 operands plus decoded control. It performs the ALU operation, evaluates the ARM condition field against a private NZCV flags register and updates those flags. A multi-cycle iterative multiply stalls upstream until it completes. Results go out through the EX/MEM pipeline register.

---
 rtl/execute_stage.sv | 204 ++++++++++++++++++++
 tb/tb_execute_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage of the pipelined ARM calculator core: ALU, condition check
// against a private NZCV register, iterative multiply and the EX/MEM register.
module execute_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] RD1,
    input  logic [WIDTH-1:0] RD2,
    input  logic [WIDTH-1:0] ExtImm,
    input  logic             ALUSrc,
    input  logic [2:0]       ALUControl,
    input  logic [1:0]       FlagWrite,
    input  logic [3:0]       Cond,
    input  logic             RegWrite_in,
    input  logic             MemWrite_in,
    input  logic [3:0]       WA_in,
    input  logic             flush,
    output logic             Stall,
    output logic             valid_out,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] WriteData,
    output logic [3:0]       WA_out,
    output logic             RegWrite_out,
    output logic             MemWrite_out,
    output logic [3:0]       Flags
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [3:0]       flags;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;

    logic             flag_n, flag_z, flag_c, flag_v;
    logic             cond_ex;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] add_b;
    logic             is_sub;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_result;
    logic             c_alu;
    logic             v_alu;
    logic             arith;
    logic             op_valid;
    logic             mul_start;

    assign {flag_n, flag_z, flag_c, flag_v} = flags;
    assign Flags = flags;

    always_comb begin
        case (Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = !flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = !flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = !flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = !flag_v;
            4'b1000: cond_ex = flag_c && !flag_z;
            4'b1001: cond_ex = !flag_c || flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ex = flag_z || (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Subtraction reuses the adder as A + ~B + 1, so carry out means A >= B.
    assign src_b  = ALUSrc ? ExtImm : RD2;
    assign is_sub = (ALUControl == OP_SUB);
    assign add_b  = is_sub ? ~src_b : src_b;
    assign sum    = {1'b0, RD1} + {1'b0, add_b} + {{WIDTH{1'b0}}, is_sub};

    // NOTE: every signal written in an always_comb gets a default first,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        alu_result = '0;
        c_alu      = flag_c;
        v_alu      = flag_v;
        arith      = 1'b0;
        op_valid   = 1'b1;
        case (ALUControl)
            OP_ADD: begin
                alu_result = sum[WIDTH-1:0];
                c_alu      = sum[WIDTH];
                v_alu      = (RD1[WIDTH-1] == src_b[WIDTH-1]) &&
                             (sum[WIDTH-1] != RD1[WIDTH-1]);
                arith      = 1'b1;
            end
            OP_SUB: begin
                alu_result = sum[WIDTH-1:0];
                c_alu      = sum[WIDTH];
                v_alu      = (RD1[WIDTH-1] != src_b[WIDTH-1]) &&
                             (sum[WIDTH-1] != RD1[WIDTH-1]);
                arith      = 1'b1;
            end
            OP_AND: alu_result = RD1 & src_b;
            OP_ORR: alu_result = RD1 | src_b;
            OP_EOR: alu_result = RD1 ^ src_b;
            // Only a condition-failing MUL takes the single-cycle path; its
            // result is never written back, so it is left at zero.
            OP_MUL: alu_result = '0;
            default: op_valid  = 1'b0;
        endcase
    end

    assign mul_start = valid_in && (ALUControl == OP_MUL) && cond_ex && !flush;
    assign Stall     = (state == BUSY) || ((state == IDLE) && mul_start);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            flags        <= '0;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            count        <= '0;
            valid_out    <= 1'b0;
            ALUResult    <= '0;
            WriteData    <= '0;
            WA_out       <= '0;
            RegWrite_out <= 1'b0;
            MemWrite_out <= 1'b0;
        end else if (flush) begin
            state        <= IDLE;
            valid_out    <= 1'b0;
            RegWrite_out <= 1'b0;
            MemWrite_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        mcand     <= RD1;
                        mplier    <= src_b;
                        acc       <= '0;
                        count     <= '0;
                        valid_out <= 1'b0;
                        state     <= BUSY;
                    end else if (valid_in) begin
                        valid_out    <= 1'b1;
                        ALUResult    <= alu_result;
                        WriteData    <= RD2;
                        WA_out       <= WA_in;
                        RegWrite_out <= RegWrite_in && cond_ex;
                        MemWrite_out <= MemWrite_in && cond_ex;
                        if (cond_ex && op_valid) begin
                            if (FlagWrite[1])
                                flags[3:2] <= {alu_result[WIDTH-1], alu_result == '0};
                            if (FlagWrite[0] && arith)
                                flags[1:0] <= {c_alu, v_alu};
                        end
                    end else begin
                        valid_out <= 1'b0;
                    end
                end
                BUSY: begin
                    valid_out <= 1'b0;
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST_ITER)
                        state <= DONE;
                end
                DONE: begin
                    // Condition was checked at start and Flags cannot change
                    // while busy, so the held MUL is committed unconditionally.
                    valid_out    <= 1'b1;
                    ALUResult    <= acc;
                    WriteData    <= RD2;
                    WA_out       <= WA_in;
                    RegWrite_out <= RegWrite_in;
                    MemWrite_out <= MemWrite_in;
                    if (FlagWrite[1])
                        flags[3:2] <= {acc[WIDTH-1], acc == '0};
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expected values.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] RD1, RD2, ExtImm;
    logic        ALUSrc;
    logic [2:0]  ALUControl;
    logic [1:0]  FlagWrite;
    logic [3:0]  Cond;
    logic        RegWrite_in, MemWrite_in;
    logic [3:0]  WA_in;
    logic        flush;
    logic        Stall, valid_out;
    logic [31:0] ALUResult, WriteData;
    logic [3:0]  WA_out;
    logic        RegWrite_out, MemWrite_out;
    logic [3:0]  Flags;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b101, RSV = 3'b110;
    localparam logic [3:0] EQ = 4'b0000, NE = 4'b0001, AL = 4'b1110;

    execute_stage #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .RD1(RD1), .RD2(RD2), .ExtImm(ExtImm), .ALUSrc(ALUSrc),
        .ALUControl(ALUControl), .FlagWrite(FlagWrite), .Cond(Cond),
        .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .WA_in(WA_in),
        .flush(flush), .Stall(Stall), .valid_out(valid_out),
        .ALUResult(ALUResult), .WriteData(WriteData), .WA_out(WA_out),
        .RegWrite_out(RegWrite_out), .MemWrite_out(MemWrite_out), .Flags(Flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic [31:0] imm, input logic [1:0] fw,
                         input logic [3:0] cond, input logic rw, input logic mw,
                         input logic [3:0] wa);
        valid_in    = 1'b1;
        ALUControl  = op;
        RD1         = a;
        RD2         = b;
        ALUSrc      = src;
        ExtImm      = imm;
        FlagWrite   = fw;
        Cond        = cond;
        RegWrite_in = rw;
        MemWrite_in = mw;
        WA_in       = wa;
    endtask

    task automatic idle();
        valid_in    = 1'b0;
        RegWrite_in = 1'b0;
        MemWrite_in = 1'b0;
    endtask

    int  stall_cycles;
    logic bubble_bad;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        idle();
        RD1 = '0; RD2 = '0; ExtImm = '0; ALUSrc = 1'b0;
        ALUControl = ADD; FlagWrite = 2'b00; Cond = AL; WA_in = '0;
        step(); step();
        reset = 1'b0;
        check("reset_valid", {31'b0, valid_out}, 32'd0);
        check("reset_flags", {28'b0, Flags}, 32'h0);
        check("reset_result", ALUResult, 32'h0);

        // Plain ADD, then hold behaviour with valid_in low
        issue(ADD, 32'd3, 32'd4, 1'b0, 32'd0, 2'b00, AL, 1'b1, 1'b0, 4'd3);
        step();
        check("add_result", ALUResult, 32'd7);
        check("add_valid", {31'b0, valid_out}, 32'd1);
        check("add_wa", {28'b0, WA_out}, 32'd3);
        check("add_regwrite", {31'b0, RegWrite_out}, 32'd1);
        idle();
        step();
        check("bubble_valid", {31'b0, valid_out}, 32'd0);
        check("bubble_hold", ALUResult, 32'd7);

        // Flag-setting arithmetic
        issue(SUB, 32'd5, 32'd5, 1'b0, 32'd0, 2'b11, AL, 1'b1, 1'b0, 4'd1);
        step();
        check("sub_zero_result", ALUResult, 32'd0);
        check("sub_zero_flags", {28'b0, Flags}, 32'b0110);

        // Forwarded Z=1: NE fails, EQ passes
        issue(ADD, 32'd1, 32'd1, 1'b0, 32'd0, 2'b11, NE, 1'b1, 1'b0, 4'd2);
        step();
        check("ne_valid", {31'b0, valid_out}, 32'd1);
        check("ne_regwrite", {31'b0, RegWrite_out}, 32'd0);
        check("ne_flags", {28'b0, Flags}, 32'b0110);
        issue(ADD, 32'd1, 32'd1, 1'b0, 32'd0, 2'b00, EQ, 1'b1, 1'b0, 4'd2);
        step();
        check("eq_regwrite", {31'b0, RegWrite_out}, 32'd1);
        check("eq_result", ALUResult, 32'd2);

        issue(ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0, 2'b11, AL, 1'b1, 1'b0, 4'd4);
        step();
        check("add_ovf_result", ALUResult, 32'h8000_0000);
        check("add_ovf_flags", {28'b0, Flags}, 32'b1001);
        issue(SUB, 32'd0, 32'd1, 1'b0, 32'd0, 2'b11, AL, 1'b1, 1'b0, 4'd4);
        step();
        check("sub_borrow_result", ALUResult, 32'hFFFF_FFFF);
        check("sub_borrow_flags", {28'b0, Flags}, 32'b1000);

        // Reserved opcode: result 0, flags untouched
        issue(RSV, 32'd9, 32'd9, 1'b0, 32'd0, 2'b11, AL, 1'b1, 1'b0, 4'd5);
        step();
        check("rsv_result", ALUResult, 32'd0);
        check("rsv_flags", {28'b0, Flags}, 32'b1000);

        // Set C=1,V=1 so the MUL can show they are preserved
        issue(ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 2'b11, AL, 1'b1, 1'b0, 4'd6);
        step();
        check("cv_setup_flags", {28'b0, Flags}, 32'b0111);

        // Iterative MUL
        issue(MUL, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 32'd0, 2'b10, AL, 1'b1, 1'b0, 4'd7);
        #1;
        stall_cycles = 0;
        bubble_bad   = 1'b0;
        while (Stall && stall_cycles < 100) begin
            stall_cycles++;
            if (stall_cycles >= 2 && valid_out) bubble_bad = 1'b1;
            @(posedge clk);
            #1;
        end
        check("mul_stall_cycles", stall_cycles, 32'd33);
        check("mul_bubble", {31'b0, bubble_bad}, 32'd0);
        check("mul_done_valid_low", {31'b0, valid_out}, 32'd0);
        step();
        check("mul_valid", {31'b0, valid_out}, 32'd1);
        check("mul_result", ALUResult, 32'hFFFF_FFFF);
        check("mul_flags", {28'b0, Flags}, 32'b1011);
        check("mul_wa", {28'b0, WA_out}, 32'd7);
        issue(ADD, 32'd2, 32'd3, 1'b0, 32'd0, 2'b00, AL, 1'b1, 1'b0, 4'd8);
        #1;
        check("post_mul_no_stall", {31'b0, Stall}, 32'd0);
        step();
        check("post_mul_add", ALUResult, 32'd5);
        check("post_mul_valid", {31'b0, valid_out}, 32'd1);

        // Flush while BUSY with count 10 (after 11 edges)
        issue(MUL, 32'd3, 32'd4, 1'b0, 32'd0, 2'b11, AL, 1'b1, 1'b0, 4'd9);
        for (int i = 0; i < 11; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        #1;
        check("flush_stall", {31'b0, Stall}, 32'd0);
        check("flush_valid", {31'b0, valid_out}, 32'd0);
        check("flush_regwrite", {31'b0, RegWrite_out}, 32'd0);
        check("flush_flags", {28'b0, Flags}, 32'b1011);
        step(); step();
        check("flush_no_result", {31'b0, valid_out}, 32'd0);

        // Asynchronous reset while BUSY with count 5 (after 6 edges)
        issue(MUL, 32'd6, 32'd7, 1'b0, 32'd0, 2'b11, AL, 1'b1, 1'b0, 4'd10);
        for (int i = 0; i < 6; i++) step();
        #2;
        reset = 1'b1;
        idle();
        #1;
        check("areset_flags", {28'b0, Flags}, 32'h0);
        check("areset_result", ALUResult, 32'h0);
        check("areset_stall", {31'b0, Stall}, 32'd0);
        step();
        reset = 1'b0;
        step(); step(); step();
        check("areset_no_result", {31'b0, valid_out}, 32'd0);
        issue(ADD, 32'd3, 32'd4, 1'b0, 32'd0, 2'b00, AL, 1'b1, 1'b0, 4'd3);
        step();
        check("after_reset_add", ALUResult, 32'd7);

        // Condition-failing MUL (Z=0, EQ): single cycle, no write
        issue(MUL, 32'd2, 32'd2, 1'b0, 32'd0, 2'b11, EQ, 1'b1, 1'b0, 4'd11);
        #1;
        check("mul_fail_no_stall", {31'b0, Stall}, 32'd0);
        step();
        check("mul_fail_valid", {31'b0, valid_out}, 32'd1);
        check("mul_fail_regwrite", {31'b0, RegWrite_out}, 32'd0);
        check("mul_fail_flags", {28'b0, Flags}, 32'h0);

        // Immediate operand and store data path
        issue(ADD, 32'd10, 32'h0000_ABCD, 1'b1, 32'h20, 2'b00, AL, 1'b0, 1'b1, 4'd12);
        step();
        check("imm_result", ALUResult, 32'h2A);
        check("store_data", WriteData, 32'h0000_ABCD);
        check("store_memwrite", {31'b0, MemWrite_out}, 32'd1);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
